empaquetador_2a8: RTL
=====================

// Module: empaquetador_2a8
// PURPOSE
//  Downstream stage of the 2-bit 2:1 mux: consumes the mux's 2-bit output stream and packs
//  consecutive symbols into WORD_W-bit words.
//  Input side: valid/ready handshake. Output side: a one-entry registered valid/ready port.
//  A flush request pads a partial word with zeros. A wrapping counter tracks delivered words.
// PARAMETERS
//  WORD_W     8  output word width; must be an even number >= 4; N_SLOT = WORD_W/2 symbols per word
//  MSB_FIRST  1  1: first symbol lands in data_out[WORD_W-1:WORD_W-2]; 0: first symbol in data_out[1:0]
// PORTS
//  clk          in   1       single clock, all state updates on posedge
//  reset_L      in   1       asynchronous, active-low reset
//  data_in      in   2       symbol from the mux output
//  valid_in     in   1       data_in is valid this cycle
//  ready_in     out  1       stage accepts a symbol this cycle; accept = valid_in & ready_in
//  flush        in   1       one-cycle pulse: close the current partial word, zero-padded
//  data_out     out  WORD_W  packed word; held stable while valid_out & !ready_out
//  valid_out    out  1       data_out holds an undelivered word
//  ready_out    in   1       consumer takes the word; deliver = valid_out & ready_out
//  slot_cnt     out  clog2(N_SLOT)  symbols currently in the accumulator
//  word_count   out  8       delivered words, modulo 256
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs are 0.
//   Specifically data_out=0, valid_out=0, slot_cnt=0, word_count=0, and the accumulator is 0.
//   ready_in is 1 once reset_L=1.
//  FSM on slot_cnt S0..S(N_SLOT-1):
//   - An accept in Sk (k<N_SLOT-1) writes the symbol into slot k and moves to Sk+1.
//   - An accept in S(N_SLOT-1) forms the word. On the next edge the word loads into data_out,
//     valid_out=1, the accumulator clears and the FSM returns to S0.
//  Latency: valid_out rises one clk after the accept that completes a word.
//  Output register:
//   - It loads whenever it is empty, or is being drained in the same cycle (deliver=1).
//   - Back-to-back full words are possible with no bubble.
//   - On deliver with no new load, valid_out falls next edge.
//  ready_in = !(slot_cnt==N_SLOT-1 && valid_out && !ready_out) && !flush_pend.
//   - Stalls only on the completing symbol while the output is blocked.
//   - ready_in is combinational from slot_cnt, valid_out, ready_out and flush_pend.
//  flush behaviour:
//   - flush with slot_cnt=0 and no accept in the same cycle: ignored, no empty word is emitted.
//   - flush with slot_cnt>0: the word, with unfilled slots = 0, loads into data_out when the
//     output register is free. Until then flush_pend=1 and ready_in=0.
//   - flush plus accept in the same cycle: the symbol is included first, then padding.
//     If that symbol completes the word, it is a normal full word.
//  word_count increments on every deliver and wraps 255->0.
//   - The increment is independent of the load in the same cycle.
//  valid_in high while ready_in=0: the symbol is not consumed; data_in is sampled again later.
//  reset_L low mid-word or mid-stall: the partial word, pending flush and held data_out are
//   discarded immediately (asynchronous).
//  Output values are X-free at all times after reset.
// TESTING
//  T1 reset_L=0 for 2 clk with valid_in=1 -> all outputs 0.
//   After release, ready_in=1 and valid_out stays 0 until 4 accepts.
//  T2 MSB_FIRST=1, ready_out=1, accept 11,10,01,00 on consecutive clk
//   -> data_out=8'hE4 and valid_out=1 exactly 1 clk after the 4th accept; word_count=1.
//  T3 ready_out=0, stream 8 symbols 11,11,11,11,00,01,10,11:
//   - first word 8'hFF is held;
//   - ready_in=0 on the 8th symbol;
//   - ready_out=1 -> 8'hFF is delivered, then 8'h1B, with no symbol lost.
//  T4 accept 11,01 then flush=1 -> data_out=8'hD0 next clk; slot_cnt=0.
//   A flush at slot_cnt=0 yields no valid_out.
//  T5 accept 10,10 then drop reset_L mid-word -> outputs 0 at once.
//   The next 4 symbols 00,00,00,01 -> 8'h01; the stale symbols do not appear.
//  T6 deliver 257 words -> word_count 255->0->1.
//   A checker compares data_out against a reference model on every deliver.

Source files
------------

// File: rtl/empaquetador_2a8.sv
// Packs a stream of 2-bit symbols into WORD_W-bit words behind a one-entry
// registered valid/ready output; flush closes a partial word with zero padding.
module empaquetador_2a8 #(
  parameter int WORD_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset_L,
  input  logic [1:0]                    data_in,
  input  logic                          valid_in,
  output logic                          ready_in,
  input  logic                          flush,
  output logic [WORD_W-1:0]             data_out,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic [$clog2(WORD_W/2)-1:0]   slot_cnt,
  output logic [7:0]                    word_count
);
  localparam int N_SLOT = WORD_W/2;
  localparam int SW     = $clog2(N_SLOT);
  localparam logic [SW-1:0] LAST = SW'(N_SLOT-1);

  logic [SW-1:0]     slot_q, slot_d;
  logic [WORD_W-1:0] acc_q, acc_d, acc_ins, dout_q, dout_d;
  logic              vout_q, vout_d, pend_q, pend_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic              accept, deliver, free, complete, close, load, stall;

  assign deliver  = vout_q & ready_out;
  assign free     = ~vout_q | ready_out;
  // Only the word-completing symbol has to wait for the output register.
  assign stall    = (slot_q == LAST) & vout_q & ~ready_out;
  assign ready_in = reset_L & ~stall & ~pend_q;
  assign accept   = valid_in & ready_in;
  assign complete = accept & (slot_q == LAST);
  assign close    = ~complete & (pend_q | (flush & (accept | (slot_q != '0))));
  assign load     = complete | (close & free);

  always_comb begin
    acc_ins = acc_q;
    for (int k = 0; k < N_SLOT; k++) begin
      if (accept && slot_q == SW'(k))
        acc_ins[(MSB_FIRST ? WORD_W-2-2*k : 2*k) +: 2] = data_in;
    end
  end

  always_comb begin
    slot_d = slot_q;
    acc_d  = acc_q;
    dout_d = dout_q;
    vout_d = vout_q;
    pend_d = pend_q;
    wcnt_d = wcnt_q + {7'd0, deliver};
    if (load) begin
      dout_d = acc_ins;
      vout_d = 1'b1;
      acc_d  = '0;
      slot_d = '0;
      pend_d = 1'b0;
    end else begin
      if (deliver) vout_d = 1'b0;
      if (accept) begin
        acc_d  = acc_ins;
        slot_d = slot_q + SW'(1);
      end
      pend_d = close;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      slot_q <= '0;
      acc_q  <= '0;
      dout_q <= '0;
      vout_q <= 1'b0;
      pend_q <= 1'b0;
      wcnt_q <= '0;
    end else begin
      slot_q <= slot_d;
      acc_q  <= acc_d;
      dout_q <= dout_d;
      vout_q <= vout_d;
      pend_q <= pend_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign data_out   = dout_q;
  assign valid_out  = vout_q;
  assign slot_cnt   = slot_q;
  assign word_count = wcnt_q;
endmodule
